bit_reverse_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational bit reverser.
- Reverses the low m bits of a W-bit operand, processing STEP bits per cycle behind a valid/ready handshake on input and output.
- Adds full-width reverse and per-byte reverse (brev8) modes for the bit-manipulation execute path.
- Single-entry unit: one operation in flight, result held until consumed.

---
 rtl/bit_reverse_seq.sv | 197 +++++++++++++++++++
 tb/tb_bit_reverse_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_reverse_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_reverse_seq
// Description : Multi-cycle bit reverser behind valid/ready handshakes.
//               Modes: 0 = reverse low m bits (STEP bits per cycle),
//               1 = reverse all W bits, 2 = per-byte reverse (brev8),
//               3 = pass-through. One operation in flight; the result is
//               held on out_data until the next result replaces it.
//               Optional macro BIT_REVERSE_ERR_EN: mode 0 with in_m > W
//               reports out_err=1 with a zero result instead of saturating.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_reverse_seq #(
    parameter int W    = 32,
    parameter int STEP = 8,
    parameter int MW   = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [MW-1:0] in_m,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_err
);

    localparam logic [MW-1:0] c_W    = MW'(W);
    localparam logic [MW-1:0] c_STEP = MW'(STEP);
    localparam logic [W-1:0]  c_ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_exit;

    logic [W-1:0]   r_b;
    logic [1:0]     r_mode;
    logic [MW-1:0]  r_m;
    logic [MW-1:0]  r_idx;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_out;

    logic [MW-1:0]  w_m_eff;
    logic [MW-1:0]  w_rem;
    logic [W-1:0]   w_rev;
    logic [W-1:0]   w_rev_m;
    logic [W-1:0]   w_hi;
    logic [W-1:0]   w_lo;
    logic [W-1:0]   w_mask;
    logic [W-1:0]   w_brev8;
    logic [W-1:0]   w_acc_nxt;

    // Full-width reversal of the latched operand; pure wiring.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_rev
            assign w_rev[gi] = r_b[W-1-gi];
        end
    endgenerate

    // Per-byte reversal of the latched operand; pure wiring.
    generate
        for (genvar gn = 0; gn < W / 8; gn++) begin : g_byte
            for (genvar gb = 0; gb < 8; gb++) begin : g_bit
                assign w_brev8[8*gn+gb] = r_b[8*gn+7-gb];
            end
        end
    endgenerate

    // Low-m reversal: reversing all W bits and shifting down by W-m puts
    // b[j] at position m-1-j. Each RUN cycle copies only the STEP result
    // positions owned by source bits idx..idx+STEP-1 (clipped at m).
    assign w_rem   = r_m - r_idx;
    assign w_rev_m = w_rev >> (c_W - r_m);
    assign w_hi    = (c_ONE << w_rem) - c_ONE;
    assign w_lo    = (w_rem > c_STEP) ? ((c_ONE << (w_rem - c_STEP)) - c_ONE) : '0;
    assign w_mask  = w_hi & ~w_lo;

    // Next accumulator value for the current RUN cycle, selected by mode.
    always_comb begin
        w_acc_nxt = r_acc;
        case (r_mode)
            2'd0, 2'd1: w_acc_nxt = r_acc | (w_rev_m & w_mask);
            2'd2:       w_acc_nxt = w_brev8;
            default:    w_acc_nxt = r_b;
        endcase
    end

    // Modes 2/3 finish in one cycle; modes 0/1 finish once the remaining
    // source bits fit in one step (m=0 included).
    assign w_exit = r_mode[1] | (w_rem <= c_STEP);

    // Effective m captured at acceptance.
    always_comb begin
        w_m_eff = '0;
        case (in_mode)
            2'd0: begin
                if (in_m > c_W) begin
`ifdef BIT_REVERSE_ERR_EN
                    w_m_eff = '0;
`else
                    w_m_eff = c_W;
`endif
                end else begin
                    w_m_eff = in_m;
                end
            end
            2'd1:    w_m_eff = c_W;
            default: w_m_eff = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                w_accept = in_valid & ~rst;
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_exit) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b    <= '0;
            r_mode <= '0;
            r_m    <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_b    <= in_data;
            r_mode <= in_mode;
            r_m    <= w_m_eff;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_idx <= r_idx + c_STEP;
            if (w_exit) r_out <= w_acc_nxt;
        end
    end

    assign out_data = r_out;

`ifdef BIT_REVERSE_ERR_EN
    logic r_err_op;
    logic r_err;

    // Error tracking: out-of-range m in mode 0 flags the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_op <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_err_op <= (in_mode == 2'd0) && (in_m > c_W);
        end else if ((r_state == S_RUN) && w_exit) begin
            r_err <= r_err_op;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_reverse_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_reverse_seq
// Description : Bench for bit_reverse_seq: behavioural result/latency model,
//               per-cycle output comparison, directed and random operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_reverse_seq;

    localparam int W    = 32;
    localparam int STEP = 8;
    localparam int MW   = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [MW-1:0] in_m;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;

    bit_reverse_seq #(.W(W), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_m      (in_m),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int vectors  = 0;
    int miscomps = 0;

    // Expected observable state, advanced by the driver.
    bit           chk_en  = 1'b0;
    bit           m_busy  = 1'b0;
    bit           m_ov    = 1'b0;
    logic [W-1:0] m_last  = '0;
    logic         m_lerr  = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscomps++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Result, error flag and RUN cycle count straight from the mode rules.
    task automatic model(input logic [W-1:0] b, input int m, input logic [1:0] mode,
                         output logic [W-1:0] res, output logic err, output int k);
        int mm;
        res = '0;
        err = 1'b0;
        k   = 1;
        case (mode)
            2'd0, 2'd1: begin
                mm = (mode == 2'd1) ? W : m;
                if (mm > W) begin
`ifdef BIT_REVERSE_ERR_EN
                    err = 1'b1;
                    mm  = -1;
`else
                    mm  = W;
`endif
                end
                if (mm >= 0) begin
                    for (int j = 0; j < mm; j++) res[mm-1-j] = b[j];
                    k = (mm == 0) ? 1 : (mm + STEP - 1) / STEP;
                end
            end
            2'd2: begin
                for (int n = 0; n < W / 8; n++)
                    for (int i = 0; i < 8; i++) res[8*n+i] = b[8*n+7-i];
            end
            default: res = b;
        endcase
    endtask

    // Per-cycle comparison of every DUT output against the expected state.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", W'(out_valid), W'(m_ov));
            chk("in_ready",  W'(in_ready),  W'(!rst && !m_busy && !m_ov));
            chk("out_data",  out_data,      m_last);
            chk("out_err",   W'(out_err),   W'(m_lerr));
        end
    end

    // One full operation; called at posedge+1 with the DUT idle.
    task automatic do_op(input logic [W-1:0] b, input int m, input logic [1:0] mode,
                         input int hold, input bit keep_valid,
                         input bit pin, input logic [W-1:0] lit, input int lit_k);
        logic [W-1:0] ed;
        logic         ee;
        int           ek;
        model(b, m, mode, ed, ee, ek);
        if (pin) begin
            chk("model_data", ed, lit);
            chk("model_k", W'(ek), W'(lit_k));
        end
        in_valid = 1'b1;
        in_data  = b;
        in_m     = MW'(m);
        in_mode  = mode;
        @(posedge clk); #1;
        m_busy = 1'b1;
        if (keep_valid) begin
            in_data = ~b;
            in_mode = 2'(mode + 2'd1);
        end else begin
            in_valid = 1'b0;
        end
        repeat (ek - 1) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        m_busy = 1'b0;
        m_ov   = 1'b1;
        m_last = ed;
        m_lerr = ee;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        m_ov      = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rb;
        int           rm;
        logic [1:0]   rmode;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_m      = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed operations with hand-computed results.
        do_op(32'hFFFF_FFFB,  4, 2'd0, 0, 1'b0, 1'b1, 32'h0000_000D, 1);
        do_op(32'h0000_0001, 32, 2'd0, 0, 1'b0, 1'b1, 32'h8000_0000, 4);
        do_op(32'h0000_F00F,  0, 2'd1, 1, 1'b0, 1'b1, 32'hF00F_0000, 4);
        do_op(32'h1234_5678,  0, 2'd0, 0, 1'b0, 1'b1, 32'h0000_0000, 1);
        do_op(32'h0102_0304,  7, 2'd2, 0, 1'b0, 1'b1, 32'h8040_C020, 1);
        do_op(32'hDEAD_BEEF,  3, 2'd3, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1);
        do_op(32'h0000_0ABC, 12, 2'd0, 3, 1'b1, 1'b1, 32'h0000_03D5, 2);
        do_op(32'hFFFF_FFFF,  9, 2'd0, 0, 1'b0, 1'b1, 32'h0000_01FF, 2);
`ifdef BIT_REVERSE_ERR_EN
        do_op(32'h0000_0001, 40, 2'd0, 0, 1'b0, 1'b1, 32'h0000_0000, 1);
`else
        do_op(32'h0000_0001, 40, 2'd0, 0, 1'b0, 1'b1, 32'h8000_0000, 4);
`endif

        // Reset during the second RUN cycle of an m=32 operation.
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        in_m     = MW'(32);
        in_mode  = 2'd0;
        @(posedge clk); #1;
        m_busy   = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        m_busy = 1'b0;
        m_ov   = 1'b0;
        m_last = '0;
        m_lerr = 1'b0;
        rst    = 1'b0;
        repeat (6) begin @(posedge clk); #1; end

        // Random operations.
        for (int t = 0; t < 200; t++) begin
            rb    = $urandom;
            rmode = 2'($urandom_range(0, 3));
            rm    = $urandom_range(0, W + 8);
            do_op(rb, rm, rmode, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'b0, '0, 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end

endmodule
`default_nettype wire
